// File: rtl/fibo_encode_scheduler.sv
`timescale 1ns/1ps
// Purpose : round-robin arbiter sharing one Fibonacci encoder among NREQ requesters.
// Latency : grant -> rsp_valid = EN_CYCLES + encoder conversion time + 1 cycles.
// Backpr. : one job in flight; rsp_* held while rsp_valid && !rsp_ready, no grants until handoff.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_data        per-requester valid and W-bit word (requester i at [i*W +: W])
//   req_ready                 one-hot single-cycle accept strobe
//   rsp_valid/rsp_ready       result handshake; rsp_id, rsp_data (0 on error), rsp_err (timeout)
//   enc_en_encode/_input_binary   encoder launch controls (this block is their only driver)
//   enc_convert_done/_fibonacci_random  encoder completion level and result
//   busy                      high whenever the scheduler is not idle
module fibo_encode_scheduler #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int W         = 16,
    parameter int EN_CYCLES = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              enc_en_encode,
    output logic [W-1:0]      enc_input_binary,
    input  logic              enc_convert_done,
    input  logic [W-1:0]      enc_fibonacci_random,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              en_q, en_d;
    logic [W-1:0]      in_bin_q, in_bin_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    cur_id_q, cur_id_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [LW-1:0]     lcnt_q, lcnt_d;
    logic              done_q, done_d;

    // Arbitration results
    logic              any_vld;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW:0]      cand;
    logic [W-1:0]      sel_data;

    // Only a rising edge counts: a level left high by an earlier job is ignored.
    logic              done_edge;
    logic              launch_last;
    logic              timeout_hit;

    assign done_edge   = enc_convert_done && !done_q;
    assign launch_last = (lcnt_q == LW'(EN_CYCLES - 1));
    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

    // Cyclic search from rr_ptr. Iterating from the far end downward lets the
    // nearest candidate overwrite the others, so no "found" flag is needed.
    always_comb begin
        any_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                any_vld = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_data = req_data[i*W +: W];
            end
        end
    end

    // State register (also holds all datapath flops)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            en_q        <= 1'b0;
            in_bin_q    <= '0;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            tcnt_q      <= '0;
            lcnt_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            en_q        <= en_d;
            in_bin_q    <= in_bin_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            tcnt_q      <= tcnt_d;
            lcnt_q      <= lcnt_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_vld)                    state_d = ST_LAUNCH;
            ST_LAUNCH: if (launch_last)                state_d = ST_WAIT;
            ST_WAIT:   if (done_edge || timeout_hit)   state_d = ST_RESULT;
            ST_RESULT: if (rsp_ready)                  state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        en_d        = en_q;
        in_bin_d    = in_bin_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        tcnt_d      = tcnt_q;
        lcnt_d      = lcnt_q;
        done_d      = enc_convert_done;

        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    req_ready_d = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
                    in_bin_d    = sel_data;
                    cur_id_d    = gnt_idx;
                    rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    // en rises together with the LAUNCH state so it is high for
                    // exactly the EN_CYCLES cycles spent there.
                    en_d        = 1'b1;
                    lcnt_d      = '0;
                end
            end
            ST_LAUNCH: begin
                if (launch_last) begin
                    en_d   = 1'b0;
                    tcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            ST_WAIT: begin
                // Completion wins over a simultaneous timeout.
                if (done_edge) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = enc_fibonacci_random;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_RESULT: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                en_d        = 1'b0;
            end
        endcase
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = rsp_err_q;
    assign enc_en_encode    = en_q;
    assign enc_input_binary = in_bin_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fibo_encode_scheduler.sv
`timescale 1ns/1ps
module tb_fibo_encode_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 16;
    localparam int EN   = 2;
    localparam int TO   = 20;
    localparam int CONV = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              enc_en_encode;
    logic [W-1:0]      enc_input_binary;
    logic              enc_convert_done;
    logic [W-1:0]      enc_fibonacci_random;
    logic              busy;

    always #5 clk = ~clk;

    fibo_encode_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .W(W), .EN_CYCLES(EN), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .enc_en_encode(enc_en_encode), .enc_input_binary(enc_input_binary),
        .enc_convert_done(enc_convert_done), .enc_fibonacci_random(enc_fibonacci_random),
        .busy(busy)
    );

    // ---------------- encoder stub: Zeckendorf code, bit i <-> Fib(i+2) ----------------
    function automatic logic [15:0] zeck(input logic [15:0] v);
        int f[16];
        int r;
        logic [15:0] o;
        f[0] = 1; f[1] = 2;
        for (int i = 2; i < 16; i++) f[i] = f[i-1] + f[i-2];
        r = int'(v);
        o = '0;
        for (int i = 15; i >= 0; i--) begin
            if (f[i] <= r) begin
                o[i] = 1'b1;
                r = r - f[i];
            end
        end
        return o;
    endfunction

    logic        stub_done = 1'b0;
    logic        stub_hang = 1'b0;
    logic        force_en  = 1'b0;
    logic        force_val = 1'b0;
    logic        en_prev   = 1'b0;
    int          stub_cnt  = 0;
    logic [15:0] stub_out  = '0;

    assign enc_convert_done     = force_en ? force_val : stub_done;
    assign enc_fibonacci_random = stub_out;

    always @(posedge clk) begin
        en_prev <= enc_en_encode;
        if (enc_en_encode && !en_prev) begin
            stub_done <= 1'b0;
            stub_out  <= zeck(enc_input_binary);
            stub_cnt  <= stub_hang ? 0 : CONV;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input int id, input logic [15:0] d, input logic e);
        exp_t x;
        x.id = id; x.data = d; x.err = e;
        return x;
    endfunction

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   en_run         = 0;
    int   wait_entry_cyc = 0;
    int   rv_rise_cyc    = 0;
    logic rv_prev        = 1'b0;

    // Monitor: pops the scoreboard on every accepted response and checks en pulse width.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid && !rv_prev) rv_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0b with nothing expected",
                             rsp_id, rsp_data, rsp_err);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id",   32'(rsp_id),   32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err",  32'(rsp_err),  32'(e.err));
                end
            end
            if (enc_en_encode) begin
                en_run++;
            end else if (en_run > 0) begin
                check("en_len", 32'(en_run), 32'(EN));
                en_run = 0;
                wait_entry_cyc = cyc;
            end
        end
        rv_prev = rsp_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic post(input int i, input logic [15:0] d);
        req_data[i*W +: W] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic grant_wait(input int exp_id, input logic [15:0] exp_d);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (req_ready == '0 && t < 300);
        if (req_ready == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got no req_ready expected grant to %0d", exp_id);
        end else begin
            check("grant_onehot", 32'(req_ready), 32'(1) << exp_id);
            check("enc_input",    32'(enc_input_binary), 32'(exp_d));
            req_valid = req_valid & ~req_ready;
            @(negedge clk);
            check("req_ready_pulse", 32'(req_ready), 32'h0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending responses busy=%0b expected 0 and 0", sb.size(), busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        check("rst_en",        32'(enc_en_encode), 32'h0);
        check("rst_in_bin",    32'(enc_input_binary), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness: all four at once, grants in index order from rr_ptr=0.
        post(0, 16'd5); post(1, 16'd9); post(2, 16'd17); post(3, 16'd105);
        sb.push_back(mk(0, 16'h0008, 1'b0));
        sb.push_back(mk(1, 16'h0011, 1'b0));
        sb.push_back(mk(2, 16'h0025, 1'b0));
        sb.push_back(mk(3, 16'h0224, 1'b0));
        grant_wait(0, 16'd5);
        grant_wait(1, 16'd9);
        grant_wait(2, 16'd17);
        grant_wait(3, 16'd105);
        wait_idle();

        // Pointer wrapped back to 0: requester 0 beats requester 2.
        post(2, 16'd17); post(0, 16'd5);
        sb.push_back(mk(0, 16'h0008, 1'b0));
        sb.push_back(mk(2, 16'h0025, 1'b0));
        grant_wait(0, 16'd5);
        grant_wait(2, 16'd17);
        wait_idle();

        // Single request (rr_ptr=3, only requester 0 valid).
        post(0, 16'd5);
        sb.push_back(mk(0, 16'h0008, 1'b0));
        grant_wait(0, 16'd5);
        wait_idle();

        // Backpressure: hold the result 10 cycles with another request pending.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        post(1, 16'd9);
        sb.push_back(mk(1, 16'h0011, 1'b0));
        grant_wait(1, 16'd9);
        begin
            int t = 0;
            while (!rsp_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        post(2, 16'd17);
        sb.push_back(mk(2, 16'h0025, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id",    32'(rsp_id),    32'h1);
            check("bp_rsp_data",  32'(rsp_data),  32'h0011);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_en",        32'(enc_en_encode), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        grant_wait(2, 16'd17);
        wait_idle();

        // Stale done: level held high across the launch must not complete the job.
        force_en  = 1'b1;
        force_val = 1'b1;
        post(3, 16'd105);
        sb.push_back(mk(3, 16'h0224, 1'b0));
        grant_wait(3, 16'd105);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stale_no_rsp", 32'(rsp_valid), 32'h0);
        end
        force_val = 1'b0;
        @(negedge clk);
        force_val = 1'b1;
        wait_idle();
        force_en = 1'b0;

        // Timeout: encoder never completes.
        stub_hang = 1'b1;
        post(1, 16'd9);
        sb.push_back(mk(1, 16'h0000, 1'b1));
        grant_wait(1, 16'd9);
        wait_idle();
        check("timeout_latency", 32'(rv_rise_cyc - wait_entry_cyc), 32'(TO));
        stub_hang = 1'b0;

        // Normal job after a timeout.
        post(2, 16'd17);
        sb.push_back(mk(2, 16'h0025, 1'b0));
        grant_wait(2, 16'd17);
        wait_idle();

        // Reset in the middle of WAIT_DONE: nothing is returned.
        stub_hang = 1'b1;
        post(3, 16'd105);
        grant_wait(3, 16'd105);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",      32'(busy),             32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid),        32'h0);
        check("mid_rst_en",        32'(enc_en_encode),    32'h0);
        check("mid_rst_in_bin",    32'(enc_input_binary), 32'h0);
        check("mid_rst_rsp_data",  32'(rsp_data),         32'h0);
        check("mid_rst_rsp_id",    32'(rsp_id),           32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stub_hang = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // rr_ptr restarts at 0: requester 0 ahead of 3.
        post(0, 16'd5); post(3, 16'd105);
        sb.push_back(mk(0, 16'h0008, 1'b0));
        sb.push_back(mk(3, 16'h0224, 1'b0));
        grant_wait(0, 16'd5);
        grant_wait(3, 16'd105);
        wait_idle();

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
